pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 34 +++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_scoreboard.sv | 78 +++++++
 rtl/pipeline_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: register-file select, register index width,
//                register counts, scoreboard index helper and FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 3;               // register index width
    localparam int NUM_REGS  = 8;               // registers per file
    localparam int RF_TYPES  = 2;               // scalar + vector files
    localparam int SB_IDX_W  = REG_IDX_W + 1;   // {type, idx}

    typedef enum logic {
        SCALAR = 1'b0,                          // 21-bit scalar file
        VECTOR = 1'b1                           // 192-bit vector file
    } rf_type_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_VBUSY = 1'b1
    } hz_state_e;

    // Scoreboard slot for a register: file select forms the MSB so the
    // scalar and vector files never alias each other.
    function automatic logic [SB_IDX_W-1:0] sb_index(input logic             rf_type,
                                                     input logic [REG_IDX_W-1:0] idx);
        return {rf_type, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl_if
//  Description : Decode-stage / hazard-controller bundle.
//                master : decode stage (drives instruction fields, flush)
//                slave  : hazard controller (drives stall/issue/bubble,
//                         vbusy and the bypass selects fwd1/fwd2)
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
    import pipeline_hazard_ctrl_pkg::*;

    logic                 dec_valid;
    logic [REG_IDX_W-1:0] src1;
    logic [REG_IDX_W-1:0] src2;
    logic                 src1_type;
    logic                 src2_type;
    logic                 src1_use;
    logic                 src2_use;
    logic [REG_IDX_W-1:0] dest;
    logic                 dest_type;
    logic                 dest_we;
    logic                 is_vec;
    logic                 flush;
    logic                 stall;
    logic                 issue;
    logic                 bubble;
    logic                 vbusy;
    logic                 fwd1;
    logic                 fwd2;

    modport master (
        output dec_valid, src1, src2, src1_type, src2_type, src1_use, src2_use,
               dest, dest_type, dest_we, is_vec, flush,
        input  stall, issue, bubble, vbusy, fwd1, fwd2
    );

    modport slave (
        input  dec_valid, src1, src2, src1_type, src2_type, src1_use, src2_use,
               dest, dest_type, dest_we, is_vec, flush,
        output stall, issue, bubble, vbusy, fwd1, fwd2
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : 16 write-back countdown counters (8 scalar, 8 vector)
//                indexed by {type, idx}, plus pending / bypass lookup for
//                two source operands.
//                Macro HAZARD_FWD_EN: a counter of exactly 1 is bypassable
//                (not pending, fwd asserted); otherwise any nonzero counter
//                is pending and fwd is constant 0.
//  Ports       : clk, rst_n           clock, async active-low reset
//                i_upd_en/i_upd_idx   load WB_LAT into slot at next edge
//                i_srcN_idx/i_srcN_use  source lookup
//                o_pendN/o_fwdN       pending / bypass select per source
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT = 3
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                i_upd_en,
    input  wire logic [SB_IDX_W-1:0] i_upd_idx,
    input  wire logic [SB_IDX_W-1:0] i_src1_idx,
    input  wire logic                i_src1_use,
    input  wire logic [SB_IDX_W-1:0] i_src2_idx,
    input  wire logic                i_src2_use,
    output logic                     o_pend1,
    output logic                     o_pend2,
    output logic                     o_fwd1,
    output logic                     o_fwd2
);

    localparam int              c_cnt_w   = $clog2(WB_LAT + 1);
    localparam int              c_num_cnt = RF_TYPES * NUM_REGS;
    localparam logic [c_cnt_w-1:0] c_load = c_cnt_w'(WB_LAT);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt [c_num_cnt];
    logic [c_cnt_w-1:0] w_cnt1;
    logic [c_cnt_w-1:0] w_cnt2;

    // A new write overrides the decrement of its own slot; all other
    // nonzero slots count down and stick at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_num_cnt; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < c_num_cnt; i++) begin
                if (i_upd_en && (i_upd_idx == SB_IDX_W'(i)))
                    r_cnt[i] <= c_load;
                else if (r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - c_one;
            end
        end
    end

    // Lookups read the pre-update value, so an instruction whose source
    // equals its own destination never hazards against itself.
    assign w_cnt1 = r_cnt[i_src1_idx];
    assign w_cnt2 = r_cnt[i_src2_idx];

`ifdef HAZARD_FWD_EN
    // Final write-back cycle: value is on the bypass network.
    assign o_pend1 = i_src1_use && (w_cnt1 > c_one);
    assign o_pend2 = i_src2_use && (w_cnt2 > c_one);
    assign o_fwd1  = i_src1_use && (w_cnt1 == c_one);
    assign o_fwd2  = i_src2_use && (w_cnt2 == c_one);
`else
    assign o_pend1 = i_src1_use && (w_cnt1 != '0);
    assign o_pend2 = i_src2_use && (w_cnt2 != '0);
    assign o_fwd1  = 1'b0;
    assign o_fwd2  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : In-order pipeline hazard controller. Detects RAW hazards
//                through a write-back scoreboard and structural hazards
//                while a multi-beat vector op occupies execute; produces
//                stall / issue / bubble and bypass selects.
//                Optional macro HAZARD_FWD_EN enables last-cycle bypassing.
//  Ports       : clk    rising-edge clock
//                rst_n  asynchronous active-low reset
//                hz     pipeline_hazard_ctrl_if.slave (decode fields in,
//                       stall/issue/bubble/vbusy/fwd1/fwd2 out)
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int WB_LAT    = 3,
    parameter int VEC_BEATS = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    localparam logic [0:0] c_st_idle   = ST_IDLE;
    localparam logic [0:0] c_st_vbusy  = ST_VBUSY;
    localparam logic       c_vec_multi = (VEC_BEATS > 1);
    // Issue cycle is beat 1, so VBUSY covers the remaining VEC_BEATS-1 beats.
    localparam logic [3:0] c_beat_load = (VEC_BEATS > 1) ? 4'(VEC_BEATS - 2) : 4'd0;

    logic [0:0] r_state;
    logic [3:0] r_beat;
    logic       w_pend1;
    logic       w_pend2;
    logic       w_raw_hz;
    logic       w_struct_hz;
    logic       w_go;
    logic       w_stall;
    logic       w_issue;

    hazard_scoreboard #(
        .WB_LAT (WB_LAT)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_upd_en   (w_issue && hz.dest_we),
        .i_upd_idx  (sb_index(hz.dest_type, hz.dest)),
        .i_src1_idx (sb_index(hz.src1_type, hz.src1)),
        .i_src1_use (hz.src1_use),
        .i_src2_idx (sb_index(hz.src2_type, hz.src2)),
        .i_src2_use (hz.src2_use),
        .o_pend1    (w_pend1),
        .o_pend2    (w_pend2),
        .o_fwd1     (hz.fwd1),
        .o_fwd2     (hz.fwd2)
    );

    assign w_raw_hz    = w_pend1 | w_pend2;
    assign w_struct_hz = (r_state == c_st_vbusy);
    // rst_n gating keeps issue low while reset is held with decode valid.
    assign w_go        = rst_n & hz.dec_valid & ~hz.flush;
    assign w_stall     = w_go & (w_raw_hz | w_struct_hz);
    assign w_issue     = w_go & ~w_stall;

    assign hz.stall  = w_stall;
    assign hz.issue  = w_issue;
    assign hz.bubble = ~w_issue;
    assign hz.vbusy  = w_struct_hz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_beat  <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_issue && hz.is_vec && c_vec_multi) begin
                        r_state <= c_st_vbusy;
                        r_beat  <= c_beat_load;
                    end
                end
                c_st_vbusy: begin
                    if (r_beat == 4'd0)
                        r_state <= c_st_idle;
                    else
                        r_beat  <= r_beat - 4'd1;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_beat  <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Directed self-checking bench for pipeline_hazard_ctrl,
//                WB_LAT=2, VEC_BEATS=4. Expectations adapt to the
//                HAZARD_FWD_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;
    import pipeline_hazard_ctrl_pkg::*;

    localparam int WB_LAT    = 2;
    localparam int VEC_BEATS = 4;
`ifdef HAZARD_FWD_EN
    localparam logic c_fwd        = 1'b1;
    localparam int   c_raw_stalls = WB_LAT - 1;  // last cycle is bypassed
`else
    localparam logic c_fwd        = 1'b0;
    localparam int   c_raw_stalls = WB_LAT;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if hif ();

    pipeline_hazard_ctrl #(
        .WB_LAT    (WB_LAT),
        .VEC_BEATS (VEC_BEATS)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic v,
                      input logic [2:0] s1, input logic s1t, input logic s1u,
                      input logic [2:0] s2, input logic s2t, input logic s2u,
                      input logic [2:0] d,  input logic dt,  input logic we,
                      input logic vec, input logic fl);
        hif.dec_valid = v;
        hif.src1 = s1;  hif.src1_type = s1t; hif.src1_use = s1u;
        hif.src2 = s2;  hif.src2_type = s2t; hif.src2_use = s2u;
        hif.dest = d;   hif.dest_type = dt;  hif.dest_we  = we;
        hif.is_vec = vec;
        hif.flush  = fl;
    endtask

    task automatic idle_op();
        op(0, 3'd0,0,0, 3'd0,0,0, 3'd0,0,0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset with a valid, hazard-free op presented
        rst_n = 1'b0;
        op(1, 3'd1,0,1, 3'd2,1,1, 3'd3,0,1, 1, 0);
        repeat (2) @(posedge clk);
        sample();
        chk("rst stall",  hif.stall,  0);
        chk("rst issue",  hif.issue,  0);
        chk("rst bubble", hif.bubble, 1);
        chk("rst vbusy",  hif.vbusy,  0);
        chk("rst fwd1",   hif.fwd1,   0);
        chk("rst fwd2",   hif.fwd2,   0);
        rst_n = 1'b1;
        idle_op();
        next_cycle();

        // ---------------- RAW on scalar r2
        op(1, 3'd0,0,0, 3'd0,0,0, 3'd2,SCALAR,1, 0, 0);
        sample();
        chk("raw wr issue", hif.issue, 1);
        next_cycle();
        op(1, 3'd2,SCALAR,1, 3'd0,0,0, 3'd0,0,0, 0, 0);
        for (int i = 0; i < c_raw_stalls; i++) begin
            sample();
            chk("raw stall",  hif.stall,  1);
            chk("raw bubble", hif.bubble, 1);
            next_cycle();
        end
        sample();
        chk("raw rd issue", hif.issue, 1);
        chk("raw rd fwd1",  hif.fwd1,  c_fwd);
        next_cycle();

        // ---------------- type separation: v5 written, r5 read
        op(1, 3'd0,0,0, 3'd0,0,0, 3'd5,VECTOR,1, 0, 0);
        sample();
        chk("sep wr issue", hif.issue, 1);
        next_cycle();
        op(1, 3'd5,SCALAR,1, 3'd5,SCALAR,1, 3'd0,0,0, 0, 0);
        sample();
        chk("sep r5 stall", hif.stall, 0);
        chk("sep r5 issue", hif.issue, 1);
        next_cycle();
        // v5 counter is now 1: stall without bypass, fwd2 with it
        op(1, 3'd0,0,0, 3'd5,VECTOR,1, 3'd0,0,0, 0, 0);
        sample();
        chk("sep v5 stall", hif.stall, !c_fwd);
        chk("sep v5 fwd2",  hif.fwd2,  c_fwd);
        idle_op();
        next_cycle();

        // ---------------- structural: vector op then independent op
        op(1, 3'd0,0,0, 3'd0,0,0, 3'd0,0,0, 1, 0);
        sample();
        chk("vec issue",   hif.issue, 1);
        chk("vec vbusy0",  hif.vbusy, 0);
        next_cycle();
        op(1, 3'd7,SCALAR,1, 3'd0,0,0, 3'd0,0,0, 0, 0);
        for (int i = 0; i < VEC_BEATS - 1; i++) begin
            sample();
            chk("vec vbusy", hif.vbusy, 1);
            chk("vec stall", hif.stall, 1);
            next_cycle();
        end
        sample();
        chk("vec done vbusy", hif.vbusy, 0);
        chk("vec done issue", hif.issue, 1);
        next_cycle();

        // ---------------- flush on a hazard cycle
        op(1, 3'd0,0,0, 3'd0,0,0, 3'd4,SCALAR,1, 0, 0);
        sample();
        chk("fl wr issue", hif.issue, 1);
        next_cycle();
        op(1, 3'd4,SCALAR,1, 3'd0,0,0, 3'd6,SCALAR,1, 0, 1);
        sample();
        chk("fl stall",  hif.stall,  0);
        chk("fl issue",  hif.issue,  0);
        chk("fl bubble", hif.bubble, 1);
        next_cycle();
        // r4 counter decremented normally to 1
        op(1, 3'd4,SCALAR,1, 3'd0,0,0, 3'd0,0,0, 0, 0);
        sample();
        chk("fl r4 stall", hif.stall, !c_fwd);
        chk("fl r4 fwd1",  hif.fwd1,  c_fwd);
        next_cycle();
        sample();
        chk("fl r4 issue", hif.issue, 1);
        next_cycle();
        // flushed write to r6 must not have been recorded
        op(1, 3'd6,SCALAR,1, 3'd0,0,0, 3'd0,0,0, 0, 0);
        sample();
        chk("fl r6 issue", hif.issue, 1);
        next_cycle();

        // ---------------- self-reference: src1 == dest
        op(1, 3'd1,SCALAR,1, 3'd0,0,0, 3'd1,SCALAR,1, 0, 0);
        sample();
        chk("self issue", hif.issue, 1);
        next_cycle();
        op(1, 3'd1,SCALAR,1, 3'd0,0,0, 3'd0,0,0, 0, 0);
        sample();
        chk("self next stall", hif.stall, 1);
        idle_op();
        repeat (2) next_cycle();

        // ---------------- reset during VBUSY with r3 counter = 2
        op(1, 3'd0,0,0, 3'd0,0,0, 3'd3,SCALAR,1, 1, 0);
        sample();
        chk("rv issue", hif.issue, 1);
        next_cycle();
        op(1, 3'd3,SCALAR,1, 3'd0,0,0, 3'd0,0,0, 0, 0);
        sample();
        chk("rv vbusy", hif.vbusy, 1);
        chk("rv stall", hif.stall, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rv rst vbusy",  hif.vbusy,  0);
        chk("rv rst issue",  hif.issue,  0);
        chk("rv rst bubble", hif.bubble, 1);
        #1 rst_n = 1'b1;
        #1;
        chk("rv r3 issue", hif.issue, 1);
        chk("rv r3 stall", hif.stall, 0);
        chk("rv r3 vbusy", hif.vbusy, 0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
